// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline constants for the hazard/stall controller.
// Holds the default MDU latency, the zero-register id, and the opcode/funct
// encodings that the decode stage uses to derive id_is_mdu / id_is_hilo.
package hazard_stall_ctrl_pkg;

    localparam int unsigned MDU_LATENCY_DEFAULT = 4;
    localparam logic [4:0]  REG_ZERO            = 5'd0;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1a;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    // mult/multu/div/divu
    function automatic logic is_mdu_op(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) &&
               (funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
    endfunction

    // mfhi/mflo/mthi/mtlo
    function automatic logic is_hilo_op(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == OP_SPECIAL) &&
               (funct inside {FUNCT_MFHI, FUNCT_MTHI, FUNCT_MFLO, FUNCT_MTLO});
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-control bundle between the decode/execute stages and the
// hazard/stall controller.
//   master: drives ID/EX instruction info, receives stall/flush controls.
//   slave : the controller itself.
interface hazard_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             id_is_mdu;
    logic             id_is_hilo;
    logic             ex_memread;
    logic [4:0]       ex_writereg;
    logic             branch_taken_ex;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             mdu_start;
    logic             mdu_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_is_hilo,
               ex_memread, ex_writereg, branch_taken_ex,
        input  pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, mdu_busy,
               stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mdu, id_is_hilo,
               ex_memread, ex_writereg, branch_taken_ex,
        output pc_write, ifid_write, ifid_flush, idex_flush, mdu_start, mdu_busy,
               stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl_mdu_busy_counter.sv
// MDU busy counter: reloads Latency when a mult/div issues, otherwise counts
// down to zero and holds. busy_o is high while the count is nonzero.
//   clk     : system clock
//   reset   : asynchronous active-high reset (abandons any count in flight)
//   start_i : MDU issue strobe
//   busy_o  : MDU still busy
module hazard_stall_ctrl_mdu_busy_counter #(
    parameter int unsigned Latency = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    output logic busy_o
);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = 4'(Latency);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = (cnt_q != 4'd0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: resolves load-use RAW (one bubble), taken
// branch squash, and MDU/HI-LO hazards (stall while the MDU is busy), and
// keeps a saturating count of stalled cycles.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : control bundle (slave side) -- ID/EX info in, PC/IF-ID/ID-EX
//           enables/flushes, MDU start/busy and stall_cycles out
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    hazard_stall_ctrl_if.slave  bus
);

    logic             load_use;
    logic             mdu_hazard;
    logic             mdu_busy;
    logic             stall_req;
    logic             mdu_start;
    logic [CNT_W-1:0] stall_q, stall_d;

    assign load_use = bus.ex_memread && (bus.ex_writereg != REG_ZERO) &&
                      ((bus.id_uses_rs && (bus.id_rs == bus.ex_writereg)) ||
                       (bus.id_uses_rt && (bus.id_rt == bus.ex_writereg)));

    assign mdu_hazard = mdu_busy && (bus.id_is_mdu || bus.id_is_hilo);

    // A taken branch squashes the ID instruction, so it never stalls.
    assign stall_req = (load_use || mdu_hazard) && !bus.branch_taken_ex;

    always_comb begin
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        mdu_start      = 1'b0;
        // Outputs are forced to their idle values while reset is held.
        if (!reset) begin
            if (bus.branch_taken_ex) begin
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end else if (stall_req) begin
                bus.pc_write   = 1'b0;
                bus.ifid_write = 1'b0;
                bus.idex_flush = 1'b1;
            end else begin
                mdu_start = bus.id_is_mdu;
            end
        end
    end

    assign bus.mdu_start = mdu_start;
    assign bus.mdu_busy  = mdu_busy;

    hazard_stall_ctrl_mdu_busy_counter #(
        .Latency (MDU_LATENCY)
    ) u_mdu_busy_counter (
        .clk     (clk),
        .reset   (reset),
        .start_i (mdu_start),
        .busy_o  (mdu_busy)
    );

    // Saturating performance counter: sticks at all-ones.
    always_comb begin
        stall_d = stall_q;
        if (stall_req && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int unsigned LAT   = 4;
    localparam int unsigned CW    = 4;  // narrow so saturation is reachable
    localparam int          SMAX  = (1 << CW) - 1;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       mdu;
        logic       hilo;
        logic       memread;
        logic [4:0] wr;
        logic       br;
    } stim_t;

    typedef struct packed {
        logic          pc_write;
        logic          ifid_write;
        logic          ifid_flush;
        logic          idex_flush;
        logic          mdu_start;
        logic          mdu_busy;
        logic [CW-1:0] stall_cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(CW)) bus ();

    hazard_stall_ctrl #(
        .MDU_LATENCY (LAT),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model state: cycles of MDU work remaining and stall count.
    int   m_rem   = 0;
    int   m_stall = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc_write",     int'(bus.pc_write),     int'(e.pc_write));
            check("ifid_write",   int'(bus.ifid_write),   int'(e.ifid_write));
            check("ifid_flush",   int'(bus.ifid_flush),   int'(e.ifid_flush));
            check("idex_flush",   int'(bus.idex_flush),   int'(e.idex_flush));
            check("mdu_start",    int'(bus.mdu_start),    int'(e.mdu_start));
            check("mdu_busy",     int'(bus.mdu_busy),     int'(e.mdu_busy));
            check("stall_cycles", int'(bus.stall_cycles), int'(e.stall_cycles));
        end
    end

    // Drive one cycle, predict its outputs, then advance the model across the edge.
    task automatic step(input logic rst_v, input stim_t s);
        exp_t e;
        bit   lu, mh, stall, start;
        reset               = rst_v;
        bus.id_rs           = s.rs;
        bus.id_rt           = s.rt;
        bus.id_uses_rs      = s.urs;
        bus.id_uses_rt      = s.urt;
        bus.id_is_mdu       = s.mdu;
        bus.id_is_hilo      = s.hilo;
        bus.ex_memread      = s.memread;
        bus.ex_writereg     = s.wr;
        bus.branch_taken_ex = s.br;

        if (rst_v) begin
            m_rem   = 0;
            m_stall = 0;
        end
        lu    = s.memread && (s.wr != 0) &&
                ((s.urs && s.rs == s.wr) || (s.urt && s.rt == s.wr));
        mh    = (m_rem > 0) && (s.mdu || s.hilo);
        stall = !rst_v && !s.br && (lu || mh);
        start = !rst_v && !s.br && !stall && s.mdu;

        e.pc_write     = !stall;
        e.ifid_write   = !stall;
        e.ifid_flush   = !rst_v && s.br;
        e.idex_flush   = !rst_v && (s.br || stall);
        e.mdu_start    = start;
        e.mdu_busy     = (m_rem > 0);
        e.stall_cycles = CW'(m_stall);
        exp_q.push_back(e);

        @(posedge clk);
        if (!rst_v) begin
            if (start)         m_rem = LAT;
            else if (m_rem > 0) m_rem = m_rem - 1;
            if (stall && m_stall < SMAX) m_stall = m_stall + 1;
        end
        #1;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t      s;
        logic [5:0] op, fn;
        logic [5:0] pool [10];
        pool = '{6'h20, FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU,
                 FUNCT_MFHI, FUNCT_MFLO, FUNCT_MTHI, FUNCT_MTLO, 6'h24};
        op        = ($urandom_range(0, 7) == 0) ? 6'h23 : OP_SPECIAL;
        fn        = pool[$urandom_range(0, 9)];
        s.rs      = 5'($urandom_range(0, 3));
        s.rt      = 5'($urandom_range(0, 3));
        s.urs     = ($urandom_range(0, 3) != 0);
        s.urt     = ($urandom_range(0, 3) != 0);
        s.mdu     = is_mdu_op(op, fn);
        s.hilo    = is_hilo_op(op, fn);
        s.memread = 1'($urandom_range(0, 1));
        s.wr      = 5'($urandom_range(0, 3));
        s.br      = ($urandom_range(0, 7) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.id_is_mdu = 0; bus.id_is_hilo = 0; bus.ex_memread = 0;
        bus.ex_writereg = '0; bus.branch_taken_ex = 0;
        @(posedge clk);
        #1;
        step(1'b1, idle());
        step(1'b1, idle());

        // Load-use: lw $8 in EX, ID reads rs=8, then clear.
        s = idle(); s.memread = 1; s.wr = 5'd8; s.rs = 5'd8; s.urs = 1;
        step(1'b0, s);
        step(1'b0, idle());
        // Same with $0 destination: no stall.
        s.wr = 5'd0; s.rs = 5'd0;
        step(1'b0, s);
        // Branch over load-use.
        s = idle(); s.memread = 1; s.wr = 5'd9; s.rt = 5'd9; s.urt = 1; s.br = 1;
        step(1'b0, s);

        // mult then mfhi for LAT cycles, then it advances.
        s = idle(); s.mdu = 1;
        step(1'b0, s);
        s = idle(); s.hilo = 1;
        for (int i = 0; i < int'(LAT) + 1; i++) step(1'b0, s);

        // Back-to-back mult issued while busy.
        s = idle(); s.mdu = 1;
        step(1'b0, s);
        step(1'b0, idle());
        step(1'b0, idle());
        for (int i = 0; i < 3; i++) step(1'b0, s);

        // MDU squashed by branch.
        for (int i = 0; i < int'(LAT); i++) step(1'b0, idle());
        s = idle(); s.mdu = 1; s.br = 1;
        step(1'b0, s);
        step(1'b0, idle());

        // Async reset mid-operation.
        s = idle(); s.mdu = 1;
        step(1'b0, s);
        step(1'b0, idle());
        s = idle(); s.memread = 1; s.wr = 5'd3; s.rs = 5'd3; s.urs = 1;
        step(1'b1, s);
        step(1'b0, idle());

        // Randomized traffic; long stall runs exercise saturation.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0), rand_stim());
        end

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
